// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the time-shared direct-form-I IIR filter.
package iir_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Wide working type so a full 2*DATA_SIZE product plus carry fits (DATA_SIZE <= 63).
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Symmetric shift toward zero, so small negative products do not bias to -1.
  function automatic wide_t dequantize(input wide_t p, input int q);
    if (p < 0) return -((-p) >>> q);
    return p >>> q;
  endfunction

  // Fits v into a signed w-bit range: clamps when en, otherwise wraps (sign-extended low w bits).
  function automatic wide_t sat(input wide_t v, input int w, input bit en);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (!en) return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_seq_mac.sv
// Single-cycle multiply, dequantise and accumulate; the accumulator is the only state.
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int QUANT_BITS = 10,
  parameter int SATURATE   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] coef,
  input  logic [DATA_SIZE-1:0] data,
  output logic [DATA_SIZE-1:0] acc
);

  logic signed [2*DATA_SIZE-1:0] prod;
  wide_t                         term;
  logic [DATA_SIZE-1:0]          acc_d, acc_q;

  // With SATURATE the product itself is clamped too, so a huge tap pins the rail instead of wrapping.
  always_comb begin
    prod  = $signed(coef) * $signed(data);
    term  = sat(dequantize(wide_t'(prod), QUANT_BITS), DATA_SIZE, SATURATE != 0);
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = DATA_SIZE'(sat(wide_t'($signed(acc_q)) + term, DATA_SIZE, SATURATE != 0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/iir_seq.sv
// FIFO-to-FIFO direct-form-I IIR with optional decimation, sharing one multiplier across all taps.
module iir_seq
  import iir_pkg::*;
#(
  parameter int                   TAPS       = 2,
  parameter int                   DECIMATION = 1,
  parameter int                   DATA_SIZE  = 32,
  parameter int                   QUANT_BITS = 10,
  parameter logic [DATA_SIZE-1:0] X_COEFFS [TAPS] = '{32'h000000B2, 32'h000000B2},
  parameter logic [DATA_SIZE-1:0] Y_COEFFS [TAPS] = '{32'h00000000, 32'hFFFFFD66},
  parameter int                   SATURATE   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  input  logic                 x_empty,
  output logic                 x_rd_en,
  output logic [DATA_SIZE-1:0] y_out,
  input  logic                 y_out_full,
  output logic                 y_wr_en
);

  localparam int MAC_LEN = 2 * TAPS - 1;
  localparam int IDX_W   = $clog2(MAC_LEN);
  localparam int CNT_W   = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  state_t                             state_q, state_d;
  logic [TAPS-1:0][DATA_SIZE-1:0]     x_hist_q, x_hist_d;
  // y_hist[j-1] holds the output from j outputs ago.
  logic [TAPS-2:0][DATA_SIZE-1:0]     y_hist_q, y_hist_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]               y_out_q, y_out_d;
  logic                               y_wr_en_q, y_wr_en_d;
  logic                               mac_clr, mac_en;
  logic [DATA_SIZE-1:0]               coef, data, acc;

  always_comb begin
    state_d   = state_q;
    x_hist_d  = x_hist_q;
    y_hist_d  = y_hist_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    y_out_d   = y_out_q;
    y_wr_en_d = 1'b0;
    x_rd_en   = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    coef      = '0;
    data      = '0;
    case (state_q)
      READ: if (!x_empty) begin
        x_rd_en  = 1'b1;
        x_hist_d = {x_hist_q[TAPS-2:0], x_in};
        if (cnt_q == CNT_W'(DECIMATION - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        for (int k = 0; k < TAPS; k++)
          if (idx_q == IDX_W'(k)) begin
            coef = X_COEFFS[k];
            data = x_hist_q[k];
          end
        for (int j = 1; j < TAPS; j++)
          if (idx_q == IDX_W'(TAPS - 1 + j)) begin
            coef = Y_COEFFS[j];
            data = y_hist_q[j-1];
          end
        if (idx_q == IDX_W'(MAC_LEN - 1)) state_d = WRITE;
      end
      WRITE: if (!y_out_full) begin
        y_out_d   = acc;
        y_wr_en_d = 1'b1;
        for (int j = TAPS - 2; j > 0; j--) y_hist_d[j] = y_hist_q[j-1];
        y_hist_d[0] = acc;
        state_d     = READ;
      end
      default: state_d = READ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= READ;
      x_hist_q  <= '0;
      y_hist_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      y_out_q   <= '0;
      y_wr_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_hist_q  <= x_hist_d;
      y_hist_q  <= y_hist_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      y_out_q   <= y_out_d;
      y_wr_en_q <= y_wr_en_d;
    end
  end

  iir_mac_unit #(
    .DATA_SIZE (DATA_SIZE),
    .QUANT_BITS(QUANT_BITS),
    .SATURATE  (SATURATE)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .clr  (mac_clr),
    .en   (mac_en),
    .coef (coef),
    .data (data),
    .acc  (acc)
  );

  assign y_out   = y_out_q;
  assign y_wr_en = y_wr_en_q;

endmodule
